// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
//   ctrl_state_t : sequencer states
//   opcode_t     : command opcodes carried in cmd[7:4]
//   tx_src_t     : owner of the byte currently on the transmitter
//   DEF_ACK_BYTE / DEF_NAK_BYTE : default response bytes
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT_TX
    } ctrl_state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_WR   = 4'h1,
        OP_RD   = 4'h2,
        OP_STRM = 4'h3
    } opcode_t;

    typedef enum logic {
        SRC_CMD,
        SRC_STREAM
    } tx_src_t;

    localparam logic [7:0] DEF_ACK_BYTE = 8'hA5;
    localparam logic [7:0] DEF_NAK_BYTE = 8'hEE;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Handshake bundle between the command sequencer, the UART command wrapper,
// the shared UART transmitter and the status-stream requester.
//   cmd_rdy/cmd/data/clr_cmd_rdy : command hand-off from the wrapper
//   resp/snd_resp/resp_sent      : byte transmit handshake
//   stat_vld/stat_byte/stat_ack  : status-stream byte hand-off
// master = sequencer side, slave = the surrounding UART/stream logic.
interface uart_cmd_ctrl_if;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        snd_resp;
    logic        resp_sent;
    logic        stat_vld;
    logic [7:0]  stat_byte;
    logic        stat_ack;

    modport master (
        input  cmd_rdy, cmd, data, resp_sent, stat_vld, stat_byte,
        output clr_cmd_rdy, resp, snd_resp, stat_ack
    );

    modport slave (
        output cmd_rdy, cmd, data, resp_sent, stat_vld, stat_byte,
        input  clr_cmd_rdy, resp, snd_resp, stat_ack
    );
endinterface

// File: rtl/uart_tx_timer.sv
// Wait-loop timer for a UART transmit byte.
//   clk, srst : clock, synchronous active-high reset
//   clear     : restart from zero (driven with the cycle a strobe is issued)
//   en        : count while waiting
//   expire    : combinational terminal-count flag, high while the count
//               sits at TIMEOUT-1 and en is set
module uart_tx_timer #(
    parameter logic [15:0] TIMEOUT = 16'd5000
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 16'd1);

    logic [CW-1:0] cnt_reg;

    assign expire = en && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (en && !expire) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: decodes 3-byte commands into register writes,
// register reads and stream control, and owns the shared transmitter
// (command responses win over the status stream).
//   clk, rst   : clock, synchronous active-high reset
//   bus        : command / transmit / stream handshakes (master modport)
//   reg_out    : config registers, reg i at [16i+15:16i]
//   reg_wr_stb : one-cycle write strobe per register
//   stream_en  : status streaming enabled
//   busy       : sequencer not idle
//   tx_timeout : one-cycle pulse when a byte is abandoned
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int          NUM_REGS   = 4,
    parameter logic [15:0] TX_TIMEOUT = 16'd5000,
    parameter logic [7:0]  ACK_BYTE   = DEF_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE   = DEF_NAK_BYTE
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_cmd_ctrl_if.master         bus,
    output logic [16*NUM_REGS-1:0]  reg_out,
    output logic [NUM_REGS-1:0]     reg_wr_stb,
    output logic                    stream_en,
    output logic                    busy,
    output logic                    tx_timeout
);
    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    ctrl_state_t state_reg, state_next;
    tx_src_t     src_reg, src_next;
    logic [7:0]  cmd_reg, cmd_next;
    logic [15:0] data_reg, data_next;
    logic [7:0]  resp_reg, resp_next;
    logic [7:0]  lo_byte_reg, lo_byte_next;
    logic        lo_pend_reg, lo_pend_next;
    logic        snd_resp_reg, snd_resp_next;
    logic        clr_cmd_rdy_reg, clr_cmd_rdy_next;
    logic        stat_ack_reg, stat_ack_next;
    logic        tx_timeout_reg, tx_timeout_next;
    logic        stream_en_reg, stream_en_next;

    logic [15:0]         regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0] reg_wr_stb_reg;
    logic [NUM_REGS-1:0] wr_hit;

    logic [3:0]  opcode;
    logic [3:0]  idx;
    logic        idx_ok;
    logic [15:0] rd_val;
    logic        timer_en;
    logic        timer_expire;

    assign opcode = cmd_reg[7:4];
    assign idx    = cmd_reg[3:0];
    assign idx_ok = {1'b0, idx} < NUM_REGS_W;

    // Index decode by comparison so an out-of-range index never addresses
    // the register array.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 4'(i)) rd_val = regs_reg[i];
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        assign wr_hit[gi] = (state_reg == EXEC) && (opcode == OP_WR) && (idx == 4'(gi));
        assign reg_out[16*gi +: 16] = regs_reg[gi];
    end

    assign timer_en = (state_reg == WAIT_TX);

    // Cleared in the same cycle a strobe is issued, so the count reads 0
    // while snd_resp is visible and tx_timeout lands TX_TIMEOUT cycles later.
    uart_tx_timer #(.TIMEOUT(TX_TIMEOUT)) u_tx_timer (
        .clk    (clk),
        .srst   (rst),
        .clear  (snd_resp_next),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_next       = state_reg;
        src_next         = src_reg;
        cmd_next         = cmd_reg;
        data_next        = data_reg;
        resp_next        = resp_reg;
        lo_byte_next     = lo_byte_reg;
        lo_pend_next     = lo_pend_reg;
        stream_en_next   = stream_en_reg;
        snd_resp_next    = 1'b0;
        clr_cmd_rdy_next = 1'b0;
        stat_ack_next    = 1'b0;
        tx_timeout_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_rdy) begin
                    cmd_next         = bus.cmd;
                    data_next        = bus.data;
                    clr_cmd_rdy_next = 1'b1;
                    state_next       = EXEC;
                end else if (stream_en_reg && bus.stat_vld) begin
                    resp_next     = bus.stat_byte;
                    snd_resp_next = 1'b1;
                    stat_ack_next = 1'b1;
                    lo_pend_next  = 1'b0;
                    src_next      = SRC_STREAM;
                    state_next    = WAIT_TX;
                end
            end
            EXEC: begin
                resp_next     = NAK_BYTE;
                lo_pend_next  = 1'b0;
                snd_resp_next = 1'b1;
                src_next      = SRC_CMD;
                state_next    = WAIT_TX;
                case (opcode)
                    OP_NOP:  resp_next = ACK_BYTE;
                    OP_WR:   if (idx_ok) resp_next = ACK_BYTE;
                    OP_RD: begin
                        if (idx_ok) begin
                            // Low byte frozen now so a later write cannot
                            // tear the read.
                            resp_next    = rd_val[15:8];
                            lo_byte_next = rd_val[7:0];
                            lo_pend_next = 1'b1;
                        end
                    end
                    OP_STRM: begin
                        stream_en_next = data_reg[0];
                        resp_next      = ACK_BYTE;
                    end
                    default: resp_next = NAK_BYTE;
                endcase
            end
            WAIT_TX: begin
                // resp_sent is not trusted in the cycle the strobe is visible.
                if (!snd_resp_reg && bus.resp_sent) begin
                    if (lo_pend_reg && src_reg == SRC_CMD) begin
                        resp_next     = lo_byte_reg;
                        snd_resp_next = 1'b1;
                        lo_pend_next  = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (timer_expire) begin
                    tx_timeout_next = 1'b1;
                    lo_pend_next    = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            src_reg         <= SRC_CMD;
            cmd_reg         <= '0;
            data_reg        <= '0;
            resp_reg        <= '0;
            lo_byte_reg     <= '0;
            lo_pend_reg     <= 1'b0;
            stream_en_reg   <= 1'b0;
            snd_resp_reg    <= 1'b0;
            clr_cmd_rdy_reg <= 1'b0;
            stat_ack_reg    <= 1'b0;
            tx_timeout_reg  <= 1'b0;
            reg_wr_stb_reg  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
        end else begin
            state_reg       <= state_next;
            src_reg         <= src_next;
            cmd_reg         <= cmd_next;
            data_reg        <= data_next;
            resp_reg        <= resp_next;
            lo_byte_reg     <= lo_byte_next;
            lo_pend_reg     <= lo_pend_next;
            stream_en_reg   <= stream_en_next;
            snd_resp_reg    <= snd_resp_next;
            clr_cmd_rdy_reg <= clr_cmd_rdy_next;
            stat_ack_reg    <= stat_ack_next;
            tx_timeout_reg  <= tx_timeout_next;
            reg_wr_stb_reg  <= wr_hit;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) regs_reg[i] <= data_reg;
            end
        end
    end

    assign bus.clr_cmd_rdy = clr_cmd_rdy_reg;
    assign bus.resp        = resp_reg;
    assign bus.snd_resp    = snd_resp_reg;
    assign bus.stat_ack    = stat_ack_reg;
    assign reg_wr_stb      = reg_wr_stb_reg;
    assign stream_en       = stream_en_reg;
    assign busy            = (state_reg != IDLE);
    assign tx_timeout      = tx_timeout_reg;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus randomized
// commands checked against a command-level reference model.
module tb_uart_cmd_ctrl;
    localparam int          NREGS = 4;
    localparam logic [15:0] TOUT  = 16'd50;
    localparam logic [7:0]  ACK   = 8'hA5;
    localparam logic [7:0]  NAK   = 8'hEE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [16*NREGS-1:0] reg_out;
    logic [NREGS-1:0]    reg_wr_stb;
    logic stream_en, busy, tx_timeout;

    uart_cmd_ctrl_if bus();

    uart_cmd_ctrl #(.NUM_REGS(NREGS), .TX_TIMEOUT(TOUT), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .reg_out    (reg_out),
        .reg_wr_stb (reg_wr_stb),
        .stream_en  (stream_en),
        .busy       (busy),
        .tx_timeout (tx_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and stream enable as the command
    // set defines them.
    logic [15:0] m_regs [NREGS];
    bit          m_stream;

    function automatic logic [63:0] model_pack();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_stream = 1'b0;
    endfunction

    // Expected response bytes and write-strobe count for one command.
    function automatic void model_cmd(input logic [7:0] c, input logic [15:0] d,
                                      output int n, output logic [7:0] e0,
                                      output logic [7:0] e1, output int ewr);
        int op, ix;
        op = int'(c[7:4]);
        ix = int'(c[3:0]);
        n = 1; e0 = NAK; e1 = 8'h00; ewr = 0;
        if (op == 0) e0 = ACK;
        else if (op == 1 && ix < NREGS) begin
            m_regs[ix] = d; e0 = ACK; ewr = 1;
        end else if (op == 2 && ix < NREGS) begin
            n = 2; e0 = m_regs[ix][15:8]; e1 = m_regs[ix][7:0];
        end else if (op == 3) begin
            m_stream = d[0]; e0 = ACK;
        end
    endfunction

    // Issue one command, acknowledge each byte two cycles after its strobe,
    // and collect what the DUT sent until it returns to idle.
    task automatic run_cmd(input logic [7:0] c, input logic [15:0] d,
                           output int n, output logic [7:0] g0, output logic [7:0] g1,
                           output int wrs, output int en, output logic [7:0] e0,
                           output logic [7:0] e1, output int ewr);
        int cd;
        bit got_clr, done;
        model_cmd(c, d, en, e0, e1, ewr);
        n = 0; g0 = 8'h00; g1 = 8'h00; wrs = 0; cd = -1; got_clr = 0; done = 0;
        @(negedge clk);
        bus.cmd_rdy = 1'b1; bus.cmd = c; bus.data = d;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.clr_cmd_rdy) begin got_clr = 1; break; end
        end
        bus.cmd_rdy = 1'b0;
        checks++;
        if (!got_clr) begin
            errors++;
            $display("FAIL clr_wait cmd=%h: clr_cmd_rdy not seen within 8 cycles, required a pulse", c);
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            bus.resp_sent = 1'b0;
            if (!busy && n > 0) begin done = 1; break; end
            if (bus.snd_resp) begin
                if (n == 0) g0 = bus.resp;
                else if (n == 1) g1 = bus.resp;
                n++;
                cd = 2;
            end
            if (reg_wr_stb != '0) wrs++;
            if (cd == 0) bus.resp_sent = 1'b1;
            if (cd >= 0) cd--;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_wait cmd=%h: busy still %b after 300 cycles, required 0", c, busy);
        end
        $display("cmd %h data %h -> bytes %0d [%h %h] wr_stb %0d", c, d, n, g0, g1, wrs);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stream_en !== 1'b0 || tx_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy/stream_en/tx_timeout=%b%b%b, required 000", busy, stream_en, tx_timeout);
        end
        checks++;
        if (bus.snd_resp !== 1'b0 || bus.clr_cmd_rdy !== 1'b0 || bus.stat_ack !== 1'b0 || bus.resp !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus snd/clr/ack=%b%b%b resp=%h, required 000 00",
                     bus.snd_resp, bus.clr_cmd_rdy, bus.stat_ack, bus.resp);
        end
        checks++;
        if (reg_out !== 64'h0 || reg_wr_stb !== 4'h0) begin
            errors++;
            $display("FAIL reset_regs reg_out=%h stb=%b, required 0", reg_out, reg_wr_stb);
        end
        rst = 1'b0;
        model_reset();
        $display("reset done");
    endtask

    task automatic test_write_latency();
        @(negedge clk);
        bus.cmd_rdy = 1'b1; bus.cmd = 8'h12; bus.data = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (bus.clr_cmd_rdy !== 1'b1 || bus.snd_resp !== 1'b0) begin
            errors++;
            $display("FAIL wr_lat_n1 clr=%b snd=%b, required clr=1 snd=0", bus.clr_cmd_rdy, bus.snd_resp);
        end
        bus.cmd_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.snd_resp !== 1'b1 || bus.resp !== ACK || reg_wr_stb !== 4'b0100) begin
            errors++;
            $display("FAIL wr_lat_n2 snd=%b resp=%h stb=%b, required 1 a5 0100", bus.snd_resp, bus.resp, reg_wr_stb);
        end
        checks++;
        if (reg_out[47:32] !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_reg2 reg2=%h, required beef", reg_out[47:32]);
        end
        m_regs[2] = 16'hBEEF;
        @(negedge clk); bus.resp_sent = 1'b1;
        @(negedge clk); bus.resp_sent = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.resp !== ACK) begin
            errors++;
            $display("FAIL wr_idle busy=%b resp=%h, required busy=0 resp held a5", busy, bus.resp);
        end
        $display("write latency: cmd 12 data beef");
    endtask

    task automatic test_read();
        int n, wrs, en, ewr;
        logic [7:0] g0, g1, e0, e1;
        run_cmd(8'h11, 16'h1234, n, g0, g1, wrs, en, e0, e1, ewr);
        checks++;
        if (n !== 1 || g0 !== ACK || wrs !== 1) begin
            errors++;
            $display("FAIL rd_setup bytes=%0d resp=%h stb=%0d, required 1 a5 1", n, g0, wrs);
        end
        run_cmd(8'h21, 16'h0000, n, g0, g1, wrs, en, e0, e1, ewr);
        checks++;
        if (n !== 2 || g0 !== 8'h12 || g1 !== 8'h34) begin
            errors++;
            $display("FAIL rd_bytes bytes=%0d data=%h%h, required 2 1234", n, g0, g1);
        end
    endtask

    task automatic test_illegal();
        int n, wrs, en, ewr;
        logic [7:0] g0, g1, e0, e1;
        logic [7:0] cmds [2];
        cmds[0] = 8'h17; cmds[1] = 8'h90;
        for (int i = 0; i < 2; i++) begin
            run_cmd(cmds[i], 16'hDEAD, n, g0, g1, wrs, en, e0, e1, ewr);
            checks++;
            if (n !== 1 || g0 !== NAK || wrs !== 0 || reg_out !== model_pack()) begin
                errors++;
                $display("FAIL illegal cmd=%h bytes=%0d resp=%h stb=%0d regs=%h, required 1 ee 0 %h",
                         cmds[i], n, g0, wrs, reg_out, model_pack());
            end
        end
    endtask

    task automatic test_random();
        int n, wrs, en, ewr, op;
        logic [7:0] g0, g1, e0, e1, c;
        logic [15:0] d;
        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 5);
            if (op == 5) op = $urandom_range(4, 15);
            c = {4'(op), 4'($urandom_range(0, 7))};
            d = 16'($urandom);
            run_cmd(c, d, n, g0, g1, wrs, en, e0, e1, ewr);
            checks++;
            if (n !== en || g0 !== e0 || (en == 2 && g1 !== e1)) begin
                errors++;
                $display("FAIL rand_resp cmd=%h bytes=%0d [%h %h], required %0d [%h %h]", c, n, g0, g1, en, e0, e1);
            end
            checks++;
            if (wrs !== ewr || reg_out !== model_pack() || stream_en !== m_stream) begin
                errors++;
                $display("FAIL rand_state cmd=%h stb=%0d regs=%h sen=%b, required %0d %h %b",
                         c, wrs, reg_out, stream_en, ewr, model_pack(), m_stream);
            end
        end
    endtask

    task automatic test_stream();
        int n, wrs, en, ewr, acks;
        logic [7:0] g0, g1, e0, e1;
        run_cmd(8'h30, 16'h0001, n, g0, g1, wrs, en, e0, e1, ewr);
        checks++;
        if (g0 !== ACK || stream_en !== 1'b1) begin
            errors++;
            $display("FAIL strm_on resp=%h sen=%b, required a5 1", g0, stream_en);
        end
        @(negedge clk); bus.stat_vld = 1'b1; bus.stat_byte = 8'h5A;
        @(negedge clk);
        checks++;
        if (bus.stat_ack !== 1'b1 || bus.snd_resp !== 1'b1 || bus.resp !== 8'h5A) begin
            errors++;
            $display("FAIL strm_byte ack=%b snd=%b resp=%h, required 1 1 5a", bus.stat_ack, bus.snd_resp, bus.resp);
        end
        bus.stat_vld = 1'b0;
        @(negedge clk); bus.resp_sent = 1'b1;
        @(negedge clk); bus.resp_sent = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL strm_idle busy=%b, required 0", busy);
        end
        bus.cmd_rdy = 1'b1; bus.cmd = 8'h00; bus.data = 16'h0000;
        bus.stat_vld = 1'b1; bus.stat_byte = 8'hC3;
        @(negedge clk);
        checks++;
        if (bus.clr_cmd_rdy !== 1'b1 || bus.stat_ack !== 1'b0) begin
            errors++;
            $display("FAIL prio_take clr=%b ack=%b, required 1 0", bus.clr_cmd_rdy, bus.stat_ack);
        end
        bus.cmd_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.snd_resp !== 1'b1 || bus.resp !== ACK || bus.stat_ack !== 1'b0) begin
            errors++;
            $display("FAIL prio_resp snd=%b resp=%h ack=%b, required 1 a5 0", bus.snd_resp, bus.resp, bus.stat_ack);
        end
        @(negedge clk); bus.resp_sent = 1'b1;
        @(negedge clk); bus.resp_sent = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stat_ack !== 1'b1 || bus.snd_resp !== 1'b1 || bus.resp !== 8'hC3) begin
            errors++;
            $display("FAIL prio_stream ack=%b snd=%b resp=%h, required 1 1 c3", bus.stat_ack, bus.snd_resp, bus.resp);
        end
        bus.stat_vld = 1'b0;
        @(negedge clk); bus.resp_sent = 1'b1;
        @(negedge clk); bus.resp_sent = 1'b0;
        run_cmd(8'h30, 16'h0000, n, g0, g1, wrs, en, e0, e1, ewr);
        acks = 0;
        bus.stat_vld = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.stat_ack) acks++;
        end
        bus.stat_vld = 1'b0;
        checks++;
        if (stream_en !== 1'b0 || acks !== 0) begin
            errors++;
            $display("FAIL strm_off sen=%b acks=%0d, required 0 0", stream_en, acks);
        end
        $display("stream: 5a, cmd-before-stream c3, disable checked");
    endtask

    task automatic test_timeout();
        int n, wrs, en, ewr, got;
        bit seen;
        logic [7:0] g0, g1, e0, e1;
        @(negedge clk);
        bus.cmd_rdy = 1'b1; bus.cmd = 8'h00; bus.data = 16'h0000;
        @(negedge clk); bus.cmd_rdy = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.snd_resp) begin seen = 1; break; end
        end
        got = -1;
        for (int k = 1; k <= int'(TOUT) + 20; k++) begin
            @(negedge clk);
            if (tx_timeout) begin got = k; break; end
        end
        checks++;
        if (!seen || got !== int'(TOUT)) begin
            errors++;
            $display("FAIL timeout_delay strobe_seen=%b cycles=%0d, required 1 %0d", seen, got, TOUT);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle busy=%b, required 0", busy);
        end
        @(negedge clk);
        checks++;
        if (tx_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse tx_timeout=%b one cycle later, required 0", tx_timeout);
        end
        run_cmd(8'h00, 16'h0000, n, g0, g1, wrs, en, e0, e1, ewr);
        checks++;
        if (n !== 1 || g0 !== ACK) begin
            errors++;
            $display("FAIL timeout_after bytes=%0d resp=%h, required 1 a5", n, g0);
        end
        $display("timeout after %0d cycles", got);
    endtask

    task automatic test_reset_mid();
        int n, wrs, en, ewr, snds;
        logic [7:0] g0, g1, e0, e1;
        run_cmd(8'h31, 16'h0001, n, g0, g1, wrs, en, e0, e1, ewr);
        run_cmd(8'h13, 16'h7788, n, g0, g1, wrs, en, e0, e1, ewr);
        @(negedge clk);
        bus.cmd_rdy = 1'b1; bus.cmd = 8'h23; bus.data = 16'h0000;
        @(negedge clk); bus.cmd_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.snd_resp !== 1'b1 || bus.resp !== 8'h77) begin
            errors++;
            $display("FAIL rstmid_hi snd=%b resp=%h, required 1 77", bus.snd_resp, bus.resp);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (busy !== 1'b0 || stream_en !== 1'b0 || bus.resp !== 8'h00 || reg_out !== 64'h0 || bus.snd_resp !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state busy=%b sen=%b resp=%h regs=%h snd=%b, required 0 0 00 0 0",
                     busy, stream_en, bus.resp, reg_out, bus.snd_resp);
        end
        snds = 0;
        bus.resp_sent = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.resp_sent = 1'b0;
            if (bus.snd_resp) snds++;
        end
        checks++;
        if (snds !== 0) begin
            errors++;
            $display("FAIL rstmid_nobyte strobes=%0d, required 0", snds);
        end
        $display("reset during read: abandoned");
    endtask

    initial begin
        bus.cmd_rdy = 1'b0; bus.cmd = 8'h00; bus.data = 16'h0000;
        bus.resp_sent = 1'b0; bus.stat_vld = 1'b0; bus.stat_byte = 8'h00;
        model_reset();
        test_reset();
        test_write_latency();
        test_read();
        test_illegal();
        test_random();
        test_stream();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART command wrapper and the rest of the design. It consumes 3-byte commands (cmd, data[15:0]) when cmd_rdy is set and decodes them into register writes, register reads and stream control. It also sequences every response byte onto the shared UART transmitter. The TX path is arbitrated between command responses (priority) and a status-stream requester.

Parameters:
NUM_REGS, 4, number of 16-bit config registers; register index must be < NUM_REGS, maximum 16.
TX_TIMEOUT, 16'd5000, clk cycles to wait for resp_sent before aborting a byte.
ACK_BYTE, 8'hA5, response byte for a successful write/NOP/stream command.
NAK_BYTE, 8'hEE, response byte for an illegal opcode or index.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
cmd_rdy  in  1  wrapper has a complete command
cmd  in  8  [7:4] opcode, [3:0] register index
data  in  16  command payload
clr_cmd_rdy  out  1  1-cycle pulse to consume the command
resp  out  8  byte to transmit
snd_resp  out  1  1-cycle transmit strobe
resp_sent  in  1  transmitter finished the byte
stat_vld  in  1  stream requester has a byte
stat_byte  in  8  stream byte
stat_ack  out  1  1-cycle pulse; stat_byte taken
reg_out  out  16*NUM_REGS  config registers, reg i at [16i+15:16i]
reg_wr_stb  out  NUM_REGS  1-cycle write strobe per register
stream_en  out  1  status streaming enabled
busy  out  1  not in IDLE
tx_timeout  out  1  1-cycle pulse on TX abort

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, all pulses 0, resp=0, reg_out=0, stream_en=0, busy=0. Reset mid-transfer abandons the transfer; no further strobes are issued.
- States are IDLE, EXEC, WAIT_TX.
- IDLE, cmd_rdy=1:
  - Latch cmd and data into internal registers.
  - Pulse clr_cmd_rdy.
  - Go to EXEC.
  - cmd_rdy takes priority over stat_vld in the same cycle.
- IDLE, cmd_rdy=0, stream_en=1, stat_vld=1:
  - resp<=stat_byte; pulse snd_resp and stat_ack together.
  - Record src=STREAM; go to WAIT_TX.
- EXEC decode (one cycle; snd_resp asserted in EXEC):
  - Opcode 0x0 NOP -> resp=ACK_BYTE.
  - Opcode 0x1 WR: if idx<NUM_REGS, reg[idx]<=data, pulse reg_wr_stb[idx], resp=ACK_BYTE. Otherwise resp=NAK_BYTE and no write.
  - Opcode 0x2 RD: if idx<NUM_REGS, resp=reg[idx][15:8] and set lo_pend. Otherwise resp=NAK_BYTE.
  - Opcode 0x3 STRM: stream_en<=data[0]; resp=ACK_BYTE.
  - Opcodes 0x4-0xF -> resp=NAK_BYTE.
  - After decode: pulse snd_resp, src=CMD, go to WAIT_TX.
- Latency: cmd_rdy high in cycle N -> clr_cmd_rdy in N+1 -> snd_resp (and any reg_wr_stb) in N+2.
- WAIT_TX:
  - resp_sent is ignored in the first cycle after snd_resp; it is sampled from the second cycle on.
  - Timeout counter clears on every snd_resp.
  - resp_sent=1 with lo_pend=1: resp<=reg[idx][7:0] captured at EXEC, pulse snd_resp, clear lo_pend, restart the counter, stay in WAIT_TX.
  - resp_sent=1 with lo_pend=0: go to IDLE.
  - Counter reaches TX_TIMEOUT-1: pulse tx_timeout, clear lo_pend, go to IDLE.
- resp holds its value between strobes.
- stream_en cleared while a stream byte is in flight: that byte completes; no new stat_ack is issued.
- cmd_rdy during EXEC/WAIT_TX: the command is left pending and serviced on return to IDLE, ahead of the stream.
- Read data is the register value latched at EXEC; a later write does not alter a read in progress.
- Counter width is $clog2(TX_TIMEOUT+1).
- Strobes never overlap: at most one snd_resp per WAIT_TX entry/byte.

Decomposition:
- Package uart_cmd_pkg holds:
  - typedef enum logic [1:0] {IDLE, EXEC, WAIT_TX} ctrl_state_t
  - typedef enum logic [3:0] opcode_t (OP_NOP=0, OP_WR=1, OP_RD=2, OP_STRM=3)
  - typedef enum logic {SRC_CMD, SRC_STREAM} tx_src_t
- Default ACK/NAK constants also live in the package.
- One natural sub-module: uart_tx_timer (load/clear on snd_resp, count enable in WAIT_TX, terminal-count pulse). It is reusable for other UART wait loops.

Test Plan:
1. Reset, then cmd=8'h12, data=16'hBEEF, cmd_rdy=1 -> clr_cmd_rdy at N+1; reg_wr_stb[2] and snd_resp at N+2 with resp=8'hA5; reg_out[47:32]=16'hBEEF. Ack resp_sent -> IDLE, busy=0.
2. Write reg1=16'h1234, then cmd=8'h21 -> snd_resp with resp=8'h12. After resp_sent, second snd_resp with resp=8'h34. After resp_sent -> IDLE; exactly 2 strobes.
3. cmd=8'h17 (idx 7 ≥ NUM_REGS) and cmd=8'h90 -> resp=8'hEE each; reg_out unchanged; no reg_wr_stb.
4. cmd=8'h30, data=16'h0001, then stat_vld=1, stat_byte=8'h5A -> stat_ack and snd_resp in the same cycle, resp=8'h5A. Assert cmd_rdy and stat_vld together in IDLE -> command is served first.
5. Issue a NOP and never assert resp_sent -> tx_timeout pulse exactly TX_TIMEOUT cycles after snd_resp; state returns to IDLE; the next command is processed normally.
6. Assert rst=1 for one cycle during WAIT_TX of a read -> no second byte; all outputs at reset values; stream_en=0.
